// File: rtl/fifo_rr_dispatcher_pkg.sv
// Shared definitions for the FIFO round-robin dispatcher and the FIFO bank wrapper.
// Holds the FSM state encodings and the default word/destination widths.
package fifo_rr_dispatcher_pkg;

  localparam int DATA_WIDTH_DEF = 6;
  localparam int DEST_BITS_DEF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_rr_dispatcher_rr_priority_picker.sv
// Combinational round-robin picker: first eligible input after ptr, searching cyclically.
// Produces a one-hot grant plus a flag saying whether anything was eligible.
module rr_priority_picker #(
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN-1:0]         eligible_i,
  input  logic [$clog2(NUM_IN)-1:0] ptr_i,
  output logic [NUM_IN-1:0]         grant_o,
  output logic                      found_o
);

  localparam int PTR_W = $clog2(NUM_IN);

  always_comb begin
    logic [PTR_W-1:0] j;
    j       = '0;
    grant_o = '0;
    found_o = 1'b0;
    for (int k = 1; k <= NUM_IN; k++) begin
      j = PTR_W'((int'(ptr_i) + k) % NUM_IN);
      if (!found_o && eligible_i[j]) begin
        grant_o[j] = 1'b1;
        found_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_dispatcher.sv
// Round-robin drain of NUM_IN upstream FIFOs into NUM_OUT downstream FIFOs,
// routed by the word's top DEST_BITS bits through a fixed 2-cycle pop/capture/push pipeline.
module fifo_rr_dispatcher
  import fifo_rr_dispatcher_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int NUM_OUT    = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEST_BITS  = DEST_BITS_DEF,
  parameter int HOLDOFF    = 2
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic [NUM_IN-1:0]            fifo_empty,
  input  logic [NUM_IN*DATA_WIDTH-1:0] fifo_data_in,
  output logic [NUM_IN-1:0]            pop,
  input  logic [NUM_OUT-1:0]           pause_in,
  output logic [NUM_OUT-1:0]           push_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [1:0]                   state,
  output logic                         error_out
);

  localparam int PTR_W = $clog2(NUM_IN);
  localparam int CNT_W = $clog2(HOLDOFF + 1);

  state_e                        state_q, state_d;
  logic [PTR_W-1:0]              ptr_q, ptr_d;
  logic [NUM_IN-1:0][CNT_W-1:0]  hold_q, hold_d;
  logic [NUM_IN-1:0]             pop_q, pop_d;
  logic [NUM_IN-1:0]             eligible, grant;
  logic                          found;
  logic [PTR_W-1:0]              grant_idx;
  logic                          vld_p0_q, vld_p1_q;
  logic [PTR_W-1:0]              idx_p0_q, idx_p1_q;
  logic [NUM_OUT-1:0]            push_q, push_d;
  logic [DATA_WIDTH-1:0]         data_q, data_d;
  logic [DATA_WIDTH-1:0]         word;
  logic [DEST_BITS-1:0]          dest;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      eligible[i] = !fifo_empty[i] && (hold_q[i] == '0);
    end
  end

  rr_priority_picker #(.NUM_IN(NUM_IN)) u_picker (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .found_o    (found)
  );

  // Pause wins over everything: the destination of a word is unknown until it is read.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|pause_in)      state_d = ST_PAUSED;
        else if (|eligible) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (|pause_in)        state_d = ST_PAUSED;
        else if (&fifo_empty) state_d = ST_IDLE;
      end
      ST_PAUSED: begin
        if (!(|pause_in)) begin
          if (|eligible)        state_d = ST_ACTIVE;
          else if (&fifo_empty) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p0: grant becomes the registered pop; the holdoff covers the empty-flag lag.
  always_comb begin
    pop_d     = (state_d == ST_ACTIVE && found) ? grant : '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
    ptr_d = (|pop_d) ? grant_idx : ptr_q;
    for (int i = 0; i < NUM_IN; i++) begin
      if (pop_d[i])              hold_d[i] = CNT_W'(HOLDOFF);
      else if (hold_q[i] != '0)  hold_d[i] = hold_q[i] - CNT_W'(1);
      else                       hold_d[i] = hold_q[i];
    end
  end

  // Stage p1: upstream read data is valid now; route it to the push registers.
  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (idx_p1_q == PTR_W'(i)) word = fifo_data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
    dest   = word[DATA_WIDTH-1 -: DEST_BITS];
    push_d = vld_p1_q ? (NUM_OUT'(1) << dest) : '0;
    data_d = vld_p1_q ? word : data_q;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= ST_IDLE;
      ptr_q    <= PTR_W'(NUM_IN - 1);
      hold_q   <= '0;
      pop_q    <= '0;
      vld_p0_q <= 1'b0;
      idx_p0_q <= '0;
      vld_p1_q <= 1'b0;
      idx_p1_q <= '0;
      push_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      pop_q    <= pop_d;
      vld_p0_q <= |pop_d;
      idx_p0_q <= grant_idx;
      vld_p1_q <= vld_p0_q;
      idx_p1_q <= idx_p0_q;
      push_q   <= push_d;
      data_q   <= data_d;
    end
  end

  assign pop       = pop_q;
  assign push_out  = push_q;
  assign data_out  = data_q;
  assign state     = state_q;
  assign error_out = |(push_q & pause_in);

endmodule

// File: tb/tb_fifo_rr_dispatcher.sv
// Bench for fifo_rr_dispatcher: behavioural upstream FIFOs with registered read data and
// empty flags, plus a scoreboard of expected pushes built from every observed pop.
module tb_fifo_rr_dispatcher;
  import fifo_rr_dispatcher_pkg::*;

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int DW = 6;

  typedef struct {
    logic [DW-1:0] word;
    int            due;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset_L = 1'b1;
  logic [NI-1:0]        fifo_empty = '1;
  logic [NI-1:0][DW-1:0] fdata = '0;
  logic [NI-1:0]        pop;
  logic [NO-1:0]        pause_in = '0;
  logic [NO-1:0]        push_out;
  logic [DW-1:0]        data_out;
  logic [1:0]           state;
  logic                 error_out;

  exp_t          sb[$];
  logic [DW-1:0] fq[NI][$];
  int            pop_log[$];
  int            pop_cyc[$];
  logic [DW-1:0] push_data_log[$];
  logic [NO-1:0] push_vec_log[$];
  logic [NI-1:0] pop_s = '0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  fifo_rr_dispatcher dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .fifo_empty   (fifo_empty),
    .fifo_data_in (fdata),
    .pop          (pop),
    .pause_in     (pause_in),
    .push_out     (push_out),
    .data_out     (data_out),
    .state        (state),
    .error_out    (error_out)
  );

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_log.delete();
    pop_cyc.delete();
    push_data_log.delete();
    push_vec_log.delete();
  endtask

  // Upstream FIFOs: a pop seen during a cycle updates read data and empty after the next edge.
  task automatic fifo_model();
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < NI; i++) begin
        if (reset_L && pop_s[i] && fq[i].size() > 0) fdata[i] = fq[i].pop_front();
        fifo_empty[i] = (fq[i].size() == 0);
      end
    end
  endtask

  task automatic scoreboard_monitor();
    int            gi;
    int            n;
    exp_t          e;
    logic [NO-1:0] exp_push;
    logic          exp_err;
    forever begin
      @(negedge clk);
      pop_s = pop;
      if (reset_L) begin
        if (pop != '0) begin
          gi = -1;
          n  = 0;
          for (int i = 0; i < NI; i++) if (pop[i]) begin gi = i; n++; end
          checks++;
          if (n != 1) begin errors++; $display("FAIL pop_onehot: got %b required one-hot", pop); end
          checks++;
          if (gi >= 0 && fq[gi].size() == 0) begin
            errors++;
            $display("FAIL pop_on_empty: got pop %b at cycle %0d required no pop of empty input", pop, cyc);
          end else if (gi >= 0) begin
            e.word = fq[gi][0];
            e.due  = cyc + 2;
            sb.push_back(e);
            pop_log.push_back(gi);
            pop_cyc.push_back(cyc);
          end
        end
        if (push_out != '0) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL push_unexpected: got push %b data %b required no push", push_out, data_out);
          end else begin
            e        = sb.pop_front();
            exp_push = NO'(1) << e.word[DW-1 -: 2];
            exp_err  = pause_in[e.word[DW-1 -: 2]];
            if (push_out !== exp_push || data_out !== e.word || cyc != e.due)
              begin
              errors++;
              $display("FAIL push: got push %b data %b cycle %0d required push %b data %b cycle %0d",
                       push_out, data_out, cyc, exp_push, e.word, e.due);
            end
            checks++;
            if (error_out !== exp_err) begin
              errors++;
              $display("FAIL error_out: got %b required %b", error_out, exp_err);
            end
          end
          push_vec_log.push_back(push_out);
          push_data_log.push_back(data_out);
        end else begin
          if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL push_missing: got no push at cycle %0d required data %b", cyc, sb[0].word);
            void'(sb.pop_front());
          end
          checks++;
          if (error_out !== 1'b0) begin
            errors++;
            $display("FAIL error_idle: got %b required 0", error_out);
          end
        end
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (t < 300 && !(sb.size() == 0 && fifo_empty == '1 && state == ST_IDLE &&
                        fq[0].size() == 0 && fq[1].size() == 0 && fq[2].size() == 0 && fq[3].size() == 0)) begin
      nclk();
      t++;
    end
    checks++;
    if (t >= 300) begin
      errors++;
      $display("FAIL drain_timeout: got state %0d pending %0d required idle with nothing pending", state, sb.size());
    end
  endtask

  task automatic test_reset();
    reset_L  = 1'b0;
    pause_in = '0;
    repeat (3) nclk();
    checks++; if (pop !== '0)      begin errors++; $display("FAIL reset_pop: got %b required 0", pop); end
    checks++; if (push_out !== '0) begin errors++; $display("FAIL reset_push: got %b required 0", push_out); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %b required 0", data_out); end
    checks++; if (state !== 2'd0)  begin errors++; $display("FAIL reset_state: got %0d required 0", state); end
    checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", error_out); end
    reset_L = 1'b1;
    repeat (2) nclk();
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] w;
    int            hit;
    clear_logs();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NI; i++) begin
        w = (i == 1 && k == 0) ? 6'b100101 : DW'($urandom);
        fq[i].push_back(w);
      end
    wait_drain();
    checks++;
    if (pop_log.size() != 12) begin errors++; $display("FAIL rr_count: got %0d pops required 12", pop_log.size()); end
    for (int k = 0; k < pop_log.size(); k++) begin
      checks++;
      if (pop_log[k] != k % NI) begin errors++; $display("FAIL rr_order[%0d]: got %0d required %0d", k, pop_log[k], k % NI); end
    end
    for (int k = 1; k < pop_cyc.size(); k++) begin
      checks++;
      if (pop_cyc[k] - pop_cyc[k-1] != 1) begin
        errors++; $display("FAIL rr_rate[%0d]: got spacing %0d required 1", k, pop_cyc[k] - pop_cyc[k-1]);
      end
    end
    hit = 0;
    for (int k = 0; k < push_data_log.size(); k++)
      if (push_data_log[k] == 6'b100101 && push_vec_log[k] == 4'b0100) hit = 1;
    checks++;
    if (hit != 1) begin errors++; $display("FAIL rr_route: got no push 0100 with data 100101 required one"); end
  endtask

  task automatic test_single_source();
    clear_logs();
    fq[2].push_back(6'b000111);
    fq[2].push_back(6'b011000);
    fq[2].push_back(6'b111010);
    wait_drain();
    checks++;
    if (pop_log.size() != 3) begin errors++; $display("FAIL single_count: got %0d pops required 3", pop_log.size()); end
    for (int k = 0; k < pop_log.size(); k++) begin
      checks++;
      if (pop_log[k] != 2) begin errors++; $display("FAIL single_src[%0d]: got %0d required 2", k, pop_log[k]); end
    end
    for (int k = 1; k < pop_cyc.size(); k++) begin
      checks++;
      if (pop_cyc[k] - pop_cyc[k-1] != 3) begin
        errors++; $display("FAIL single_rate[%0d]: got spacing %0d required 3", k, pop_cyc[k] - pop_cyc[k-1]);
      end
    end
    checks++;
    if (push_data_log.size() != 3) begin errors++; $display("FAIL single_pushes: got %0d required 3", push_data_log.size()); end
  endtask

  task automatic test_pause();
    int t;
    clear_logs();
    fq[0].push_back(6'b110001);
    fq[0].push_back(6'b110010);
    fq[0].push_back(6'b001111);
    t = 0;
    while (t < 50 && pop == '0) begin nclk(); t++; end
    checks++;
    if (t >= 50) begin errors++; $display("FAIL pause_first_pop: got no pop required one"); end
    @(posedge clk);
    #1;
    pause_in = 4'b1000;
    nclk();
    nclk();
    checks++; if (state !== 2'd2)       begin errors++; $display("FAIL pause_state: got %0d required 2", state); end
    checks++; if (push_out !== 4'b1000) begin errors++; $display("FAIL pause_inflight: got %b required 1000", push_out); end
    checks++; if (error_out !== 1'b1)   begin errors++; $display("FAIL pause_err: got %b required 1", error_out); end
    checks++; if (data_out !== 6'b110001) begin errors++; $display("FAIL pause_data: got %b required 110001", data_out); end
    repeat (4) nclk();
    checks++; if (pop_log.size() != 1) begin errors++; $display("FAIL pause_stall: got %0d pops required 1", pop_log.size()); end
    @(posedge clk);
    #1;
    pause_in = '0;
    nclk();
    checks++; if (pop !== '0)     begin errors++; $display("FAIL pause_release_pop: got %b required 0", pop); end
    nclk();
    checks++; if (pop !== 4'b0001) begin errors++; $display("FAIL pause_resume: got %b required 0001", pop); end
    checks++; if (state !== 2'd1)  begin errors++; $display("FAIL pause_active: got %0d required 1", state); end
    wait_drain();
    checks++; if (pop_log.size() != 3) begin errors++; $display("FAIL pause_total: got %0d pops required 3", pop_log.size()); end
  endtask

  task automatic test_wrap_idle();
    fq[3].push_back(6'b010101);
    wait_drain();
    clear_logs();
    fq[0].push_back(6'b101010);
    wait_drain();
    checks++;
    if (pop_log.size() != 1 || pop_log[0] != 0) begin
      errors++; $display("FAIL wrap_grant: got %0d pops first %0d required one pop of 0", pop_log.size(),
                         (pop_log.size() > 0) ? pop_log[0] : -1);
    end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_state: got %0d required 0", state); end
    checks++; if (pop !== '0)     begin errors++; $display("FAIL idle_pop: got %b required 0", pop); end
    fq[3].push_back(6'b000001);
    wait_drain();
    clear_logs();
    fq[2].push_back(6'b100010);
    fq[0].push_back(6'b010011);
    wait_drain();
    checks++;
    if (pop_log.size() != 2 || pop_log[0] != 0 || pop_log[1] != 2) begin
      errors++; $display("FAIL wrap_order: got %0d pops required order 0,2", pop_log.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < NI; i++) fq[i].push_back(DW'($urandom));
    repeat (6) nclk();
    #2;
    reset_L = 1'b0;
    #1;
    checks++; if (pop !== '0)      begin errors++; $display("FAIL rstmid_pop: got %b required 0", pop); end
    checks++; if (push_out !== '0) begin errors++; $display("FAIL rstmid_push: got %b required 0", push_out); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL rstmid_data: got %b required 0", data_out); end
    checks++; if (state !== 2'd0)  begin errors++; $display("FAIL rstmid_state: got %0d required 0", state); end
    checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b required 0", error_out); end
    sb.delete();
    for (int i = 0; i < NI; i++) fq[i].delete();
    clear_logs();
    repeat (2) nclk();
    reset_L = 1'b1;
    repeat (5) nclk();
    checks++; if (push_out !== '0) begin errors++; $display("FAIL rstmid_stale: got %b required 0", push_out); end
    for (int i = 0; i < NI; i++) fq[i].push_back(DW'($urandom));
    wait_drain();
    checks++;
    if (pop_log.size() != 4 || pop_log[0] != 0) begin
      errors++; $display("FAIL rstmid_first: got %0d pops first %0d required 4 pops first 0", pop_log.size(),
                         (pop_log.size() > 0) ? pop_log[0] : -1);
    end
  endtask

  initial begin
    fork
      fifo_model();
      scoreboard_monitor();
    join_none
    test_reset();
    test_round_robin();
    test_single_source();
    test_pause();
    test_wrap_idle();
    test_reset_mid();
    repeat (3) nclk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
